msu_data_server: RTL and testbench

// Host-side responder for the MSU-1 register block. Serves the data-track byte stream: on seek, fetches
// 64-bit lines from external memory, double-buffers them and returns the byte at data_addr on each data_req.

---
 rtl/msu_pkg.sv | 29 ++
 rtl/msu_data_server_if.sv | 14 +
 rtl/msu_track_ctrl.sv | 114 +++++++++++
 rtl/msu_data_server.sv | 203 ++++++++++++++++++++
 tb/tb_msu_data_server.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msu_pkg.sv
// Shared types and sizes for the MSU-1 data/track server.
package msu_pkg;

    localparam int unsigned LINE_BYTES = 8;
    localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
    localparam int unsigned LINE_W     = 8 * LINE_BYTES;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned TRACK_W    = 16;
    localparam int unsigned TIMER_W    = 24;

    typedef enum logic [1:0] {
        D_IDLE,
        D_FETCH_CUR,
        D_FETCH_NXT,
        D_STREAM
    } dstate_e;

    typedef enum logic {
        T_IDLE,
        T_WAIT
    } tstate_e;

    // Little-endian byte select within a memory line.
    function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0]  off);
        return line[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/msu_data_server_if.sv
// Line-read bus between the data server and the memory arbiter.
interface msu_data_server_if #(
    parameter int unsigned MEM_AW = 29
) ();

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [63:0]       mem_dout;
    logic              mem_ready;

    modport master (output mem_addr, output mem_rd, input mem_dout, input mem_ready);
    modport slave  (input mem_addr, input mem_rd, output mem_dout, output mem_ready);

endinterface

// File: rtl/msu_track_ctrl.sv
// Track-mount handshake with the HPS: request pulse, wait for ack or timeout.
module msu_track_ctrl
    import msu_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT = TIMER_W'(10000000)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [TRACK_W-1:0] track_num,
    input  logic               track_request,
    output logic               track_mounting,
    output logic               status_track_missing,
    output logic [TRACK_W-1:0] hps_track_num,
    output logic               hps_track_req,
    input  logic               hps_track_ack,
    input  logic               hps_track_missing
);

    tstate_e              tstate_q, tstate_d;
    logic                 req_prev_q;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 ack_pend_q, ack_pend_d;
    logic                 miss_pend_q, miss_pend_d;
    logic                 mounting_q, mounting_d;
    logic                 missing_q, missing_d;
    logic [TRACK_W-1:0]   num_q, num_d;
    logic                 hps_req_q, hps_req_d;

    logic req_edge;
    logic done_ack;
    logic done_to;

    assign req_edge = track_request && !req_prev_q;
    // An ack in the first wait cycle is held so mounting stays up for at least two cycles.
    assign done_ack = (hps_track_ack || ack_pend_q) && (timer_q != '0);
    assign done_to  = (timer_q == TIMEOUT - TIMER_W'(1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tstate_q    <= T_IDLE;
            req_prev_q  <= 1'b0;
            timer_q     <= '0;
            ack_pend_q  <= 1'b0;
            miss_pend_q <= 1'b0;
            mounting_q  <= 1'b0;
            missing_q   <= 1'b0;
            num_q       <= '0;
            hps_req_q   <= 1'b0;
        end else begin
            tstate_q    <= tstate_d;
            req_prev_q  <= track_request;
            timer_q     <= timer_d;
            ack_pend_q  <= ack_pend_d;
            miss_pend_q <= miss_pend_d;
            mounting_q  <= mounting_d;
            missing_q   <= missing_d;
            num_q       <= num_d;
            hps_req_q   <= hps_req_d;
        end
    end

    always_comb begin
        tstate_d = tstate_q;
        case (tstate_q)
            T_IDLE:  if (req_edge) tstate_d = T_WAIT;
            T_WAIT:  if (done_ack || done_to) tstate_d = T_IDLE;
            default: tstate_d = T_IDLE;
        endcase
    end

    always_comb begin
        timer_d     = timer_q;
        ack_pend_d  = ack_pend_q;
        miss_pend_d = miss_pend_q;
        mounting_d  = mounting_q;
        missing_d   = missing_q;
        num_d       = num_q;
        hps_req_d   = 1'b0;
        case (tstate_q)
            T_IDLE: begin
                ack_pend_d = 1'b0;
                if (req_edge) begin
                    num_d      = track_num;
                    hps_req_d  = 1'b1;
                    mounting_d = 1'b1;
                    timer_d    = '0;
                end
            end
            T_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (hps_track_ack && !ack_pend_q) begin
                    ack_pend_d  = 1'b1;
                    miss_pend_d = hps_track_missing;
                end
                if (done_ack) begin
                    missing_d  = ack_pend_q ? miss_pend_q : hps_track_missing;
                    mounting_d = 1'b0;
                    ack_pend_d = 1'b0;
                end else if (done_to) begin
                    missing_d  = 1'b1;
                    mounting_d = 1'b0;
                    ack_pend_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign track_mounting       = mounting_q;
    assign status_track_missing = missing_q;
    assign hps_track_num        = num_q;
    assign hps_track_req        = hps_req_q;

endmodule

// File: rtl/msu_data_server.sv
// MSU-1 data-track byte server: seek, double-buffered line fetch, per-request byte return.
module msu_data_server
    import msu_pkg::*;
#(
    parameter int unsigned        MEM_AW  = 29,
    parameter logic [TIMER_W-1:0] TIMEOUT = TIMER_W'(10000000)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic               data_seek,
    input  logic               data_req,
    output logic [7:0]         data,
    output logic               data_ack,
    msu_data_server_if.master  mem,
    input  logic [TRACK_W-1:0] track_num,
    input  logic               track_request,
    output logic               track_mounting,
    output logic               status_track_missing,
    output logic [TRACK_W-1:0] hps_track_num,
    output logic               hps_track_req,
    input  logic               hps_track_ack,
    input  logic               hps_track_missing
);

    dstate_e             dstate_q, dstate_d;
    logic                seek_prev_q;
    logic                rd_out_q, rd_out_d;
    logic                stale_q, stale_d;
    logic [MEM_AW-1:0]   line_q, line_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [LINE_W-1:0]   cur_q, cur_d;
    logic [LINE_W-1:0]   nxt_q, nxt_d;
    logic                nxt_valid_q, nxt_valid_d;
    logic                pend_q, pend_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [7:0]          data_q, data_d;
    logic                ack_q, ack_d;

    logic                seek_edge;
    logic                accepted;
    logic                fresh;
    logic                crossing;
    logic                issue;
    logic [MEM_AW-1:0]   issue_line;

    assign seek_edge = data_seek && !seek_prev_q;
    // mem_ready only counts when we own a read; this also drops responses that straddle a reset.
    assign accepted  = mem.mem_ready && rd_out_q;
    assign fresh     = accepted && !stale_q;
    assign crossing  = data_req && (data_addr[OFF_W-1:0] == '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dstate_q    <= D_IDLE;
            seek_prev_q <= 1'b0;
            rd_out_q    <= 1'b0;
            stale_q     <= 1'b0;
            line_q      <= '0;
            off_q       <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            nxt_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            data_q      <= '0;
            ack_q       <= 1'b0;
        end else begin
            dstate_q    <= dstate_d;
            seek_prev_q <= data_seek;
            rd_out_q    <= rd_out_d;
            stale_q     <= stale_d;
            line_q      <= line_d;
            off_q       <= off_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
            pend_q      <= pend_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        dstate_d = dstate_q;
        if (seek_edge) begin
            dstate_d = D_FETCH_CUR;
        end else begin
            case (dstate_q)
                D_FETCH_CUR: if (fresh) dstate_d = D_FETCH_NXT;
                D_FETCH_NXT: if (accepted) dstate_d = D_STREAM;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_out_d    = rd_out_q && !mem.mem_ready;
        stale_d     = stale_q;
        line_d      = line_q;
        off_d       = off_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        pend_d      = pend_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        data_d      = data_q;
        ack_d       = 1'b0;
        issue       = 1'b0;
        issue_line  = line_q + MEM_AW'(1);

        if (seek_edge) begin
            line_d      = MEM_AW'(data_addr[ADDR_W-1:OFF_W]);
            off_d       = data_addr[OFF_W-1:0];
            stale_d     = rd_out_q && !mem.mem_ready;
            nxt_valid_d = 1'b0;
            pend_d      = 1'b0;
        end else begin
            case (dstate_q)
                D_FETCH_CUR: begin
                    if (accepted) stale_d = 1'b0;
                    if (fresh) begin
                        cur_d      = mem.mem_dout;
                        issue      = 1'b1;
                        issue_line = line_q + MEM_AW'(1);
                    end else if (!rd_out_q) begin
                        issue      = 1'b1;
                        issue_line = line_q;
                    end
                end
                D_FETCH_NXT: begin
                    if (accepted) begin
                        nxt_d       = mem.mem_dout;
                        nxt_valid_d = 1'b1;
                        data_d      = line_byte(cur_q, off_q);
                        ack_d       = 1'b1;
                    end
                end
                D_STREAM: begin
                    // Line advance comes from NXT, the arriving word, or waits as an underrun.
                    if (pend_q || (crossing && !nxt_valid_q)) begin
                        if (accepted) begin
                            cur_d      = mem.mem_dout;
                            line_d     = line_q + MEM_AW'(1);
                            data_d     = mem.mem_dout[7:0];
                            pend_d     = 1'b0;
                            issue      = 1'b1;
                            issue_line = line_q + MEM_AW'(2);
                        end else begin
                            pend_d = 1'b1;
                        end
                    end else if (crossing) begin
                        cur_d       = nxt_q;
                        line_d      = line_q + MEM_AW'(1);
                        data_d      = nxt_q[7:0];
                        nxt_valid_d = 1'b0;
                        issue       = 1'b1;
                        issue_line  = line_q + MEM_AW'(2);
                    end else begin
                        if (data_req) data_d = line_byte(cur_q, data_addr[OFF_W-1:0]);
                        if (accepted) begin
                            nxt_d       = mem.mem_dout;
                            nxt_valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (issue) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = issue_line;
            rd_out_d   = 1'b1;
        end
    end

    assign data         = data_q;
    assign data_ack     = ack_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;

    msu_track_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_track (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .track_num            (track_num),
        .track_request        (track_request),
        .track_mounting       (track_mounting),
        .status_track_missing (status_track_missing),
        .hps_track_num        (hps_track_num),
        .hps_track_req        (hps_track_req),
        .hps_track_ack        (hps_track_ack),
        .hps_track_missing    (hps_track_missing)
    );

endmodule

// File: tb/tb_msu_data_server.sv
// Directed bench for msu_data_server: vector table for seek/stream plus hand sequences for corner cases.
module tb_msu_data_server;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] data_addr;
    logic        data_seek;
    logic        data_req;
    logic [7:0]  data;
    logic        data_ack;
    logic [15:0] track_num;
    logic        track_request;
    logic        track_mounting;
    logic        status_track_missing;
    logic [15:0] hps_track_num;
    logic        hps_track_req;
    logic        hps_track_ack;
    logic        hps_track_missing;

    msu_data_server_if #(.MEM_AW(29)) mem_bus ();

    msu_data_server #(
        .MEM_AW  (29),
        .TIMEOUT (24'd1000)
    ) dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .data_addr            (data_addr),
        .data_seek            (data_seek),
        .data_req             (data_req),
        .data                 (data),
        .data_ack             (data_ack),
        .mem                  (mem_bus),
        .track_num            (track_num),
        .track_request        (track_request),
        .track_mounting       (track_mounting),
        .status_track_missing (status_track_missing),
        .hps_track_num        (hps_track_num),
        .hps_track_req        (hps_track_req),
        .hps_track_ack        (hps_track_ack),
        .hps_track_missing    (hps_track_missing)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int nack  = 0;
    int nrd   = 0;
    int nhreq = 0;
    logic [28:0] last_raddr = '0;

    int          mem_delay = 0;
    bit          mem_busy  = 1'b0;
    int          mem_cnt   = 0;
    logic [28:0] mem_line  = '0;

    typedef struct {
        logic        seek;
        logic [31:0] addr;
        logic [7:0]  exp_data;
        int          exp_rd;
        logic [28:0] exp_raddr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference line content: byte k of line l is (8*l + k) mod 256.
    function automatic logic [63:0] line_data(input logic [28:0] l);
        logic [63:0] v;
        logic [7:0]  b;
        b = {l[4:0], 3'b000};
        for (int k = 0; k < 8; k++) v[8*k +: 8] = b + 8'(k);
        return v;
    endfunction

    always @(posedge CLK) begin
        if (data_ack) nack++;
        if (mem_bus.mem_rd) begin
            nrd++;
            last_raddr = mem_bus.mem_addr;
        end
        if (hps_track_req) nhreq++;
    end

    // Memory responder: one read at a time, mem_ready mem_delay+1 cycles after mem_rd.
    initial begin
        bit was_busy;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_dout  = '0;
        forever begin
            @(negedge CLK);
            was_busy = mem_busy;
            mem_bus.mem_ready = 1'b0;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    mem_bus.mem_ready = 1'b1;
                    mem_bus.mem_dout  = line_data(mem_line);
                    mem_busy = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            if (mem_bus.mem_rd) begin
                total++;
                if (was_busy) begin
                    bad++;
                    $display("FAIL mem_overlap: mem_rd line %0h while line %0h outstanding", mem_bus.mem_addr, mem_line);
                end
                mem_busy = 1'b1;
                mem_line = mem_bus.mem_addr;
                mem_cnt  = mem_delay;
            end
        end
    end

    task automatic do_seek(input logic [31:0] a, input int bound);
        int a0;
        int k;
        a0 = nack;
        data_addr = a;
        data_seek = 1'b1;
        k = 0;
        while (nack == a0 && k < bound) begin
            @(negedge CLK);
            k++;
        end
        total++;
        if (nack == a0) begin
            bad++;
            $display("FAIL seek_ack_timeout: addr %h got no data_ack within %0d cycles", a, bound);
        end
        data_seek = 1'b0;
    endtask

    task automatic req_chk(input logic [31:0] a, input logic [7:0] exp);
        data_addr = a;
        data_req  = 1'b1;
        @(negedge CLK);
        data_req = 1'b0;
        @(negedge CLK);
        chk($sformatf("req_%0h", a), 64'(data), 64'(exp));
    endtask

    task automatic run_mount(input logic [15:0] num, input int ack_at, input logic miss,
                             input bit toggle, output int mcount);
        int k;
        mcount = 0;
        track_num = num;
        track_request = 1'b1;
        @(negedge CLK);
        k = 0;
        while (!hps_track_req && k < 10) begin
            @(negedge CLK);
            k++;
        end
        total++;
        if (!hps_track_req) begin
            bad++;
            $display("FAIL mount_start: hps_track_req never pulsed for track %h", num);
        end
        chk("hps_track_num", 64'(hps_track_num), 64'(num));
        k = 0;
        while (track_mounting && k < 5000) begin
            hps_track_ack = 1'b0;
            mcount++;
            if (mcount == ack_at) begin
                hps_track_ack     = 1'b1;
                hps_track_missing = miss;
            end
            if (toggle && mcount == 50) track_request = 1'b0;
            if (toggle && mcount == 52) begin
                track_num     = 16'h0999;
                track_request = 1'b1;
            end
            @(negedge CLK);
            k++;
        end
        hps_track_ack = 1'b0;
        track_request = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0;
        int rd0;
        int hr0;
        int k;
        int mc;

        vecs[0]  = '{1'b1, 32'h0000_0005, 8'h05, 2, 29'h1};
        vecs[1]  = '{1'b0, 32'h0000_0006, 8'h06, 0, 29'h0};
        vecs[2]  = '{1'b0, 32'h0000_0007, 8'h07, 0, 29'h0};
        vecs[3]  = '{1'b0, 32'h0000_0008, 8'h08, 1, 29'h2};
        vecs[4]  = '{1'b0, 32'h0000_0009, 8'h09, 0, 29'h0};
        vecs[5]  = '{1'b0, 32'h0000_000A, 8'h0A, 0, 29'h0};
        vecs[6]  = '{1'b1, 32'hFFFF_FFFE, 8'hFE, 2, 29'h0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 8'hFF, 0, 29'h0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 8'h00, 1, 29'h1};
        vecs[9]  = '{1'b0, 32'h0000_0001, 8'h01, 0, 29'h0};
        vecs[10] = '{1'b1, 32'h0000_0123, 8'h23, 2, 29'h25};
        vecs[11] = '{1'b0, 32'h0000_0124, 8'h24, 0, 29'h0};

        RST_N = 1'b0;
        data_addr = '0;
        data_seek = 1'b0;
        data_req = 1'b0;
        track_num = '0;
        track_request = 1'b0;
        hps_track_ack = 1'b0;
        hps_track_missing = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        chk("rst_data", 64'(data), 64'h0);
        chk("rst_data_ack", 64'(data_ack), 64'h0);
        chk("rst_mem_rd", 64'(mem_bus.mem_rd), 64'h0);
        chk("rst_mem_addr", 64'(mem_bus.mem_addr), 64'h0);
        chk("rst_mounting", 64'(track_mounting), 64'h0);
        chk("rst_missing", 64'(status_track_missing), 64'h0);
        chk("rst_hps_req", 64'(hps_track_req), 64'h0);
        chk("rst_hps_num", 64'(hps_track_num), 64'h0);

        // Request while idle is ignored.
        rd0 = nrd;
        req_chk(32'h0000_0003, 8'h00);
        repeat (2) @(negedge CLK);
        chk("idle_req_no_rd", 64'(nrd - rd0), 64'h0);

        mem_delay = 0;
        for (int i = 0; i < 12; i++) begin
            ack0 = nack;
            rd0  = nrd;
            @(negedge CLK);
            if (vecs[i].seek) begin
                do_seek(vecs[i].addr, 200);
            end else begin
                data_addr = vecs[i].addr;
                data_req  = 1'b1;
                @(negedge CLK);
                data_req  = 1'b0;
            end
            repeat (4) @(negedge CLK);
            chk($sformatf("vec%0d_data", i), 64'(data), 64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_acks", i), 64'(nack - ack0), vecs[i].seek ? 64'h1 : 64'h0);
            chk($sformatf("vec%0d_rds", i), 64'(nrd - rd0), 64'(vecs[i].exp_rd));
            if (vecs[i].exp_rd > 0)
                chk($sformatf("vec%0d_raddr", i), 64'(last_raddr), 64'(vecs[i].exp_raddr));
        end

        // Underrun: next line still in flight at the line crossing.
        mem_delay = 40;
        for (int a = 32'h125; a <= 32'h12F; a++) req_chk(32'(a), 8'(a));
        ack0 = nack;
        data_addr = 32'h0000_0130;
        data_req  = 1'b1;
        @(negedge CLK);
        data_req  = 1'b0;
        repeat (10) @(negedge CLK);
        chk("underrun_hold", 64'(data), 64'h2F);
        k = 0;
        while (data !== 8'h30 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("underrun_release", 64'(data), 64'h30);
        chk("underrun_no_ack", 64'(nack - ack0), 64'h0);
        req_chk(32'h0000_0131, 8'h31);

        // Reseek while the next-line fetch is still outstanding.
        ack0 = nack;
        rd0  = nrd;
        do_seek(32'h0000_0A53, 400);
        repeat (4) @(negedge CLK);
        chk("reseek_data", 64'(data), 64'h53);
        chk("reseek_acks", 64'(nack - ack0), 64'h1);
        chk("reseek_rds", 64'(nrd - rd0), 64'h2);
        chk("reseek_raddr", 64'(last_raddr), 64'h14B);

        // Reset with a read outstanding; its late mem_ready must be ignored.
        mem_delay = 20;
        data_addr = 32'h0000_0040;
        data_seek = 1'b1;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        data_seek = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        ack0 = nack;
        rd0  = nrd;
        chk("midrst_data", 64'(data), 64'h0);
        k = 0;
        while (mem_busy && k < 100) begin
            @(negedge CLK);
            k++;
        end
        repeat (3) @(negedge CLK);
        chk("midrst_stale_data", 64'(data), 64'h0);
        chk("midrst_no_ack", 64'(nack - ack0), 64'h0);
        chk("midrst_no_rd", 64'(nrd - rd0), 64'h0);
        mem_delay = 0;
        do_seek(32'h0000_0041, 200);
        repeat (4) @(negedge CLK);
        chk("post_rst_seek", 64'(data), 64'h41);

        // Track mount acked after 100 cycles; a second request edge mid-mount is ignored.
        hr0 = nhreq;
        run_mount(16'h0102, 100, 1'b0, 1'b1, mc);
        chk("mount_cycles", 64'(mc), 64'd100);
        chk("mount_missing", 64'(status_track_missing), 64'h0);
        chk("mount_req_pulses", 64'(nhreq - hr0), 64'h1);
        chk("mount_num_held", 64'(hps_track_num), 64'h0102);

        // No ack: timeout after 1000 cycles.
        run_mount(16'h0203, 0, 1'b0, 1'b0, mc);
        chk("timeout_cycles", 64'(mc), 64'd1000);
        chk("timeout_missing", 64'(status_track_missing), 64'h1);

        // Stray ack while idle.
        hps_track_ack = 1'b1;
        hps_track_missing = 1'b0;
        @(negedge CLK);
        hps_track_ack = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_ack_missing", 64'(status_track_missing), 64'h1);
        chk("idle_ack_mounting", 64'(track_mounting), 64'h0);

        // Immediate ack still yields a two-cycle mount.
        run_mount(16'h0304, 1, 1'b0, 1'b0, mc);
        chk("fast_ack_cycles", 64'(mc), 64'd2);
        chk("fast_ack_missing", 64'(status_track_missing), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
